// File: rtl/pwm_pkg.sv
// Shared types for the PWM block: alignment mode and counter direction encoding.
// No logic, no latency.
// No flow control; constants only.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/pwm_period_cnt.sv
// Period counter: edge mode 0..P, center mode 0..P..1; flags the last cycle of each period.
// cnt_o is registered; bnd_o is combinational on the current count.
// en_i low freezes count and direction; bnd_o is forced low.
module pwm_period_cnt
    import pwm_pkg::*;
#(
    parameter int WIDTH = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic [WIDTH-1:0] period_i,
    input  pwm_mode_e        mode_i,
    output logic [WIDTH-1:0] cnt_o,
    output logic             bnd_o
);

    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic             wrap;

    // Next count and direction; wrap marks the final cycle of the period.
    // Comparisons use >= / <= so a count left above a shrunken period still terminates.
    always_comb begin
        wrap  = 1'b0;
        cnt_d = cnt_q + CNT_ONE;
        dir_d = dir_q;
        if (period_i == '0) begin
            wrap = 1'b1;
        end else if (mode_i == PWM_EDGE) begin
            dir_d = DIR_UP;
            wrap  = (cnt_q >= period_i);
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= period_i) begin
                // P==1: the top is also the last down-count value
                if (cnt_q == CNT_ONE) begin
                    wrap = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                    dir_d = DIR_DOWN;
                end
            end
        end else begin
            if (cnt_q <= CNT_ONE) begin
                wrap = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
        if (wrap) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end
    end

    // Count register; holds while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else if (en_i) begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign cnt_o = cnt_q;
    assign bnd_o = en_i & wrap;

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM: shared period counter, NUM_CH compares, double-buffered period/duty/mode.
// pwm_out is registered one cycle behind cnt_out; tc pulses the cycle after a period boundary.
// enable low freezes counter and outputs; optional dead-time/complementary outputs via PWM_DEADTIME_EN.
module pwm_gen_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 15,
    parameter int NUM_CH   = 4,
    parameter int DEADTIME = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    mode,
    input  logic                    cfg_wr,
    input  logic [WIDTH-1:0]        period_in,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    output logic [WIDTH-1:0]        cnt_out,
    output logic                    tc,
    output logic [NUM_CH-1:0]       pwm_out
`ifdef PWM_DEADTIME_EN
    ,
    output logic [NUM_CH-1:0]       pwm_out_n
`endif
);

    logic                    bnd;
    logic                    load_act;
    logic [WIDTH-1:0]        pend_period_q, act_period_q, period_src;
    logic [NUM_CH*WIDTH-1:0] pend_duty_q, act_duty_q, duty_src;
    pwm_mode_e               pend_mode_q, act_mode_q, mode_src;
    logic                    tc_q;
    logic [NUM_CH-1:0]       raw;

    // A write coinciding with a reload goes straight to the active set
    assign period_src = cfg_wr ? period_in : pend_period_q;
    assign duty_src   = cfg_wr ? duty_in : pend_duty_q;
    assign mode_src   = cfg_wr ? pwm_mode_e'(mode) : pend_mode_q;
    assign load_act   = !enable || bnd;

    // Shadow registers: cfg_wr fills pending; active reloads while stopped or at a boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_period_q <= '0;
            pend_duty_q   <= '0;
            pend_mode_q   <= PWM_EDGE;
            act_period_q  <= '0;
            act_duty_q    <= '0;
            act_mode_q    <= PWM_EDGE;
        end else begin
            if (cfg_wr) begin
                pend_period_q <= period_in;
                pend_duty_q   <= duty_in;
                pend_mode_q   <= pwm_mode_e'(mode);
            end
            if (load_act) begin
                act_period_q <= period_src;
                act_duty_q   <= duty_src;
                act_mode_q   <= mode_src;
            end
        end
    end

    pwm_period_cnt #(
        .WIDTH(WIDTH)
    ) u_cnt (
        .clk     (clk),
        .reset   (reset),
        .en_i    (enable),
        .period_i(act_period_q),
        .mode_i  (act_mode_q),
        .cnt_o   (cnt_out),
        .bnd_o   (bnd)
    );

    // Registered boundary flag; masked while the counter is stopped
    always_ff @(posedge clk) begin
        if (reset) begin
            tc_q <= 1'b0;
        end else begin
            tc_q <= bnd;
        end
    end

    assign tc = tc_q & enable;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_cmp
        assign raw[i] = (cnt_out < act_duty_q[i*WIDTH +: WIDTH]);
    end

`ifdef PWM_DEADTIME_EN
    localparam int               DTW     = $clog2(DEADTIME + 2);
    localparam logic [DTW-1:0]   DT_LOAD = DTW'(DEADTIME);
    localparam logic [DTW-1:0]   DT_ONE  = DTW'(1);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_dt
        logic           sig_q;
        logic [DTW-1:0] dt_q;
        logic           p_q, n_q;

        // Any raw edge blanks both sides for DEADTIME enabled cycles before the new side drives
        always_ff @(posedge clk) begin
            if (reset) begin
                sig_q <= 1'b0;
                dt_q  <= '0;
                p_q   <= 1'b0;
                n_q   <= 1'b0;
            end else if (enable) begin
                if (raw[i] != sig_q) begin
                    sig_q <= raw[i];
                    dt_q  <= DT_LOAD;
                    p_q   <= 1'b0;
                    n_q   <= 1'b0;
                end else if (dt_q > DT_ONE) begin
                    dt_q <= dt_q - DT_ONE;
                end else begin
                    dt_q <= '0;
                    p_q  <= raw[i];
                    n_q  <= ~raw[i];
                end
            end
        end

        assign pwm_out[i]   = p_q;
        assign pwm_out_n[i] = n_q;
    end
`else
    logic [NUM_CH-1:0] pwm_q;

    // Output register; holds while stopped
    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_q <= '0;
        end else if (enable) begin
            pwm_q <= raw;
        end
    end

    assign pwm_out = pwm_q;
`endif

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Bench for pwm_gen_multi: phase-based reference model compared every cycle,
// directed scenarios with hand-computed expectations, then randomized config/enable/reset traffic.
module tb_pwm_gen_multi;

    localparam int WIDTH    = 15;
    localparam int NUM_CH   = 4;
    localparam int DEADTIME = 2;

    logic                    clk = 1'b0;
    logic                    reset, enable, mode, cfg_wr;
    logic [WIDTH-1:0]        period_in;
    logic [NUM_CH*WIDTH-1:0] duty_in;
    logic [WIDTH-1:0]        cnt_out;
    logic                    tc;
    logic [NUM_CH-1:0]       pwm_out;
`ifdef PWM_DEADTIME_EN
    logic [NUM_CH-1:0]       pwm_out_n;
`endif

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    pwm_gen_multi #(
        .WIDTH(WIDTH), .NUM_CH(NUM_CH), .DEADTIME(DEADTIME)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode), .cfg_wr(cfg_wr),
        .period_in(period_in), .duty_in(duty_in), .cnt_out(cnt_out), .tc(tc),
        .pwm_out(pwm_out)
`ifdef PWM_DEADTIME_EN
        , .pwm_out_n(pwm_out_n)
`endif
    );

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: position within the period ----------------
    int                 m_phase;
    int                 a_per, p_per;
    logic               a_mode, p_mode;
    int                 a_duty[NUM_CH], p_duty[NUM_CH];
    logic [NUM_CH-1:0]  m_pwm, m_pwmn;
    logic               m_tc;
    logic [DEADTIME:0]  m_hist[NUM_CH];

    function automatic int per_len(input int p, input logic md);
        if (md) return (p == 0) ? 1 : 2 * p;
        return p + 1;
    endfunction

    // Center mode: rises to P on the first half, falls back toward 1 on the second
    function automatic int phase_cnt(input int ph, input int p, input logic md);
        if (md && ph > p) return 2 * p - ph;
        return ph;
    endfunction

    always @(posedge clk) begin : model
        int   len, c;
        logic bnd, r;
        if (reset) begin
            m_phase = 0; a_per = 0; p_per = 0; a_mode = 0; p_mode = 0;
            m_pwm = '0; m_pwmn = '0; m_tc = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                a_duty[i] = 0; p_duty[i] = 0; m_hist[i] = '0;
            end
        end else begin
            len = per_len(a_per, a_mode);
            c   = phase_cnt(m_phase, a_per, a_mode);
            bnd = enable && (m_phase == len - 1);
            if (enable) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    r = (c < a_duty[i]);
`ifdef PWM_DEADTIME_EN
                    // A side drives only after raw has been steady for DEADTIME+1 samples
                    m_hist[i] = {m_hist[i][DEADTIME-1:0], r};
                    m_pwm[i]  = &m_hist[i];
                    m_pwmn[i] = ~|m_hist[i];
`else
                    m_pwm[i]  = r;
`endif
                end
                m_phase = bnd ? 0 : m_phase + 1;
            end
            m_tc = bnd;
            if (cfg_wr) begin
                p_per  = int'(period_in);
                p_mode = mode;
                for (int i = 0; i < NUM_CH; i++) p_duty[i] = int'(duty_in[i*WIDTH +: WIDTH]);
            end
            if (!enable || bnd) begin
                a_per  = p_per;
                a_mode = p_mode;
                for (int i = 0; i < NUM_CH; i++) a_duty[i] = p_duty[i];
            end
        end
    end

    // Single compare process on the falling edge
    always @(negedge clk) begin
        if (chk_on) begin
            check("cnt_out", int'(cnt_out), phase_cnt(m_phase, a_per, a_mode));
            check("tc", int'(tc), int'(m_tc & enable));
            check("pwm_out", int'(pwm_out), int'(m_pwm));
`ifdef PWM_DEADTIME_EN
            check("pwm_out_n", int'(pwm_out_n), int'(m_pwmn));
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input int p, input logic md, input int d0, input int d1, input int d2, input int d3);
        period_in = WIDTH'(p);
        mode      = md;
        duty_in   = {WIDTH'(d3), WIDTH'(d2), WIDTH'(d1), WIDTH'(d0)};
        cfg_wr    = 1'b1;
        tick();
        cfg_wr    = 1'b0;
    endtask

    task automatic wait_cnt(input int v);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (int'(cnt_out) != v && n < 200);
        if (int'(cnt_out) != v) begin
            checks++;
            errors++;
            $display("FAIL wait_cnt: cnt_out=%0d never reached %0d", cnt_out, v);
        end
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int  hi0, hi1, hi2, ntc, hn;
        int  exp2[9];
        int  p;
        bit  dirty;
        exp2 = '{0, 1, 2, 3, 4, 3, 2, 1, 0};

        reset = 1'b1; enable = 1'b0; mode = 1'b0; cfg_wr = 1'b0;
        period_in = '0; duty_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_on = 1'b1;
        @(negedge clk);
        check("rst_cnt", int'(cnt_out), 0);
        check("rst_tc", int'(tc), 0);
        check("rst_pwm", int'(pwm_out), 0);
`ifdef PWM_DEADTIME_EN
        check("rst_pwm_n", int'(pwm_out_n), 0);
`endif
        #1;
        reset = 1'b0;

        // P=9 edge: ch0 duty 3, ch1 duty 0 (always low), ch2 duty 10 (> P, always high)
        cfg(9, 1'b0, 3, 0, 10, 0);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        hi0 = 0; hi1 = 0; hi2 = 0; ntc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]); hi1 += int'(pwm_out[1]); hi2 += int'(pwm_out[2]); ntc += int'(tc);
        end
        check("edge_tc_per_20", ntc, 2);
`ifndef PWM_DEADTIME_EN
        check("edge_duty3_hi", hi0, 6);
        check("duty0_const_low", hi1, 0);
        check("duty_gt_p_const_high", hi2, 20);
`endif

        // Duty write mid-period must not disturb the running period
        #1;
        wait_cnt(5);
        cfg(9, 1'b0, 7, 0, 10, 0);
        hi0 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]);
        end
        check("old_period_cnt", int'(cnt_out), 9);
        check("old_duty_kept", hi0, 0);
        hi0 = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]);
        end
`ifndef PWM_DEADTIME_EN
        check("new_duty7_hi", hi0, 7);
`endif

        // Stop at cnt=6: everything freezes
        #1;
        wait_cnt(6);
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_cnt", int'(cnt_out), 6);
            check("hold_tc", int'(tc), 0);
`ifndef PWM_DEADTIME_EN
            check("hold_pwm", int'(pwm_out), 5);
`endif
        end
        #1;
        enable = 1'b1;
        wait_cnt(4);
        reset = 1'b1;
        @(negedge clk);
        check("midrun_rst_cnt", int'(cnt_out), 0);
        check("midrun_rst_pwm", int'(pwm_out), 0);
        check("midrun_rst_tc", int'(tc), 0);
        #1;
        reset = 1'b0; enable = 1'b0;

        // P=4 center: 0 appears once per period, so cnt<2 on 0,1 and the down-count 1
        cfg(4, 1'b1, 2, 0, 0, 0);
        enable = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            check("center_seq", int'(cnt_out), exp2[k]);
        end
        hi0 = 0; ntc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]); ntc += int'(tc);
        end
        check("center_tc_per_8", ntc, 1);
`ifndef PWM_DEADTIME_EN
        check("center_duty2_hi", hi0, 3);
`endif

`ifdef PWM_DEADTIME_EN
        // P=9, duty 5: each side loses DEADTIME cycles of its 5-cycle half
        #1;
        do_reset();
        enable = 1'b0;
        cfg(9, 1'b0, 5, 0, 0, 0);
        enable = 1'b1;
        repeat (12) @(negedge clk);
        hi0 = 0; hn = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            hi0 += int'(pwm_out[0]); hn += int'(pwm_out_n[0]);
        end
        check("dt_pwm_hi", hi0, 3);
        check("dt_pwm_n_hi", hn, 3);
`endif

        // Randomized traffic; config only lands where counter and model positions agree
        #1;
        enable = 1'b0;
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            dirty = (p_per != a_per) || (p_mode != a_mode);
            for (int i = 0; i < NUM_CH; i++) if (p_duty[i] != a_duty[i]) dirty = 1'b1;
            cfg_wr = 1'b0;
            reset  = ($urandom_range(0, 499) == 0);
            if (enable) begin
                if (!dirty && $urandom_range(0, 9) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                enable = 1'b1;
            end
            if ((enable && $urandom_range(0, 7) == 0) ||
                (!enable && m_phase == 0 && $urandom_range(0, 3) == 0)) begin
                p         = $urandom_range(0, 12);
                period_in = WIDTH'(p);
                mode      = 1'($urandom_range(0, 1));
                for (int i = 0; i < NUM_CH; i++) begin
                    if ($urandom_range(0, 9) == 0) duty_in[i*WIDTH +: WIDTH] = '1;
                    else duty_in[i*WIDTH +: WIDTH] = WIDTH'($urandom_range(0, p + 2));
                end
                cfg_wr = 1'b1;
            end
            tick();
        end
        cfg_wr = 1'b0;
        @(negedge clk);
        #1;
        chk_on = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
